// File: rtl/point_bank_ctrl_if.sv
// Output point stream of point_bank_ctrl: one {id, coordinates} record per transfer.
// Handshake: the master holds out_valid and data_o stable until the cycle where out_valid & out_rdy, which is the transfer.
interface point_bank_ctrl_if #(
  parameter int WIDTH_ID   = 2,
  parameter int WIDTH_DATA = 384
);
  logic                              out_valid;
  logic                              out_rdy;
  logic [WIDTH_ID+2*WIDTH_DATA-1:0]  data_o;

  modport master (output out_valid, output data_o, input out_rdy);
  modport slave  (input out_valid, input data_o, output out_rdy);
endinterface

// File: rtl/point_bank_ctrl.sv
// Ping-pong point-memory bank controller: fills banks from a loader and streams full
// banks, pass by pass, with the matching bucket IDs through a 2-entry output FIFO.
module point_bank_ctrl #(
  parameter int WIDTH_ID   = 2,
  parameter int WIDTH_DATA = 384,
  parameter int P_NUM      = 16,
  parameter int N_BANK     = 2,
  parameter int ID_WORD_W  = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_start,
  output logic                          load_rdy,
  output logic                          w_en,
  output logic [$clog2(P_NUM)-1:0]      w_addr,
  output logic [$clog2(N_BANK)-1:0]     w_bank,
  output logic                          load_done,
  input  logic                          msm_start,
  input  logic [7:0]                    cfg_npass,
  input  logic                          pass_next,
  output logic                          r_en,
  output logic [$clog2(P_NUM)-1:0]      r_addr,
  output logic [$clog2(N_BANK)-1:0]     r_bank,
  output logic                          id_r_en,
  output logic [$clog2(N_BANK*256*((P_NUM+ID_WORD_W/WIDTH_ID-1)/(ID_WORD_W/WIDTH_ID)))-1:0] id_r_addr,
  input  logic [2*WIDTH_DATA-1:0]       data_i,
  input  logic [ID_WORD_W-1:0]          id_i,
  point_bank_ctrl_if.master             strm,
  output logic                          pass_done,
  output logic                          msm_done,
  output logic [N_BANK-1:0]             bank_full,
  output logic [1:0]                    dbg_state
);
  localparam int PAW = $clog2(P_NUM);
  localparam int BAW = $clog2(N_BANK);
  localparam int K   = ID_WORD_W / WIDTH_ID;
  localparam int IPP = (P_NUM + K - 1) / K;
  localparam int IAW = $clog2(N_BANK * 256 * IPP);
  localparam int CW  = PAW + 1;
  localparam int DW  = WIDTH_ID + 2 * WIDTH_DATA;

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, WAIT_PASS = 2'd2} rd_state_t;

  // ---------------- load side ----------------
  logic             loading;
  logic [PAW-1:0]   w_cnt;
  logic [BAW-1:0]   wr_ptr;
  logic             load_accept;
  logic             last_write;

  assign load_rdy    = !loading && !bank_full[wr_ptr];
  assign load_accept = load_start && load_rdy;
  assign last_write  = loading && (w_cnt == PAW'(P_NUM - 1));
  assign w_en        = loading;
  assign w_addr      = w_cnt;
  assign w_bank      = wr_ptr;
  assign load_done   = last_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loading <= 1'b0;
      w_cnt   <= '0;
      wr_ptr  <= '0;
    end else if (load_accept) begin
      loading <= 1'b1;
      w_cnt   <= '0;
    end else if (loading) begin
      w_cnt <= w_cnt + PAW'(1);
      if (last_write) begin
        loading <= 1'b0;
        wr_ptr  <= wr_ptr + BAW'(1);
      end
    end
  end

  // ---------------- read side ----------------
  rd_state_t        state, state_nx;
  logic [BAW-1:0]   rd_ptr;
  logic [7:0]       npass_l;
  logic [7:0]       pass;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    pop_cnt;
  logic             inflight;
  logic [PAW-1:0]   inflight_idx;
  logic [DW-1:0]    fifo_mem [2];
  logic             fifo_wp, fifo_rp;
  logic [1:0]       fifo_cnt;
  logic             msm_accept, issue, pop, pass_end, last_pass;
  logic [WIDTH_ID-1:0] cap_id;

  assign msm_accept = (state == IDLE) && msm_start && bank_full[rd_ptr];
  assign pop        = strm.out_valid && strm.out_rdy;
  assign last_pass  = (pass == npass_l - 8'd1);
  assign pass_end   = (state == STREAM) && pop && (pop_cnt == CW'(P_NUM - 1));
  // Buffer slots are reserved at issue time, so a stalled consumer never loses a returning read.
  assign issue      = (state == STREAM) && (idx < CW'(P_NUM)) &&
                      ((3'(fifo_cnt) + 3'(inflight)) < 3'd2);

  assign r_en      = issue;
  assign r_addr    = idx[PAW-1:0];
  assign r_bank    = rd_ptr;
  assign id_r_en   = issue;
  assign id_r_addr = (IAW'(rd_ptr) * IAW'(npass_l) + IAW'(pass)) * IAW'(IPP) + IAW'(32'(idx) / K);
  assign pass_done = pass_end;
  assign msm_done  = pass_end && last_pass;
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (msm_accept) state_nx = STREAM;
      STREAM:    if (pass_end)   state_nx = last_pass ? IDLE : WAIT_PASS;
      WAIT_PASS: if (pass_next)  state_nx = STREAM;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      npass_l      <= 8'd1;
      pass         <= '0;
      idx          <= '0;
      pop_cnt      <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
    end else begin
      if (msm_accept) begin
        npass_l <= (cfg_npass == 8'd0) ? 8'd1 : cfg_npass;
        pass    <= '0;
        idx     <= '0;
        pop_cnt <= '0;
      end else if (state == WAIT_PASS && pass_next) begin
        pass    <= pass + 8'd1;
        idx     <= '0;
        pop_cnt <= '0;
      end else begin
        if (issue)         idx     <= idx + CW'(1);
        if (pass_end)      pop_cnt <= '0;
        else if (pop)      pop_cnt <= pop_cnt + CW'(1);
      end
      if (msm_done) rd_ptr <= rd_ptr + BAW'(1);
      inflight <= issue;
      if (issue) inflight_idx <= idx[PAW-1:0];
    end
  end

  // ---------------- bank occupancy ----------------
  logic [N_BANK-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (last_write) set_mask = N_BANK'(1) << wr_ptr;
    if (msm_done)   clr_mask = N_BANK'(1) << rd_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_full <= '0;
    else        bank_full <= (bank_full | set_mask) & ~clr_mask;
  end

  // ---------------- output FIFO ----------------
  always_comb cap_id = id_i[(int'(inflight_idx) % K) * WIDTH_ID +: WIDTH_ID];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= '0;
    end else begin
      if (inflight) begin
        fifo_mem[fifo_wp] <= {cap_id, data_i};
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign strm.out_valid = (fifo_cnt != 2'd0);
  assign strm.data_o    = fifo_mem[fifo_rp];

endmodule

// File: doc/point_bank_ctrl.md
POINT_BANK_CTRL -- requirements
Module: point_bank_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_ID, default 2, meaning bucket-ID bits per point.
REQ-002 SHALL have parameter WIDTH_DATA, default 384, meaning bits per coordinate.
REQ-003 SHALL have parameter P_NUM, default 16, meaning points per bank (power of two, >=2).
REQ-004 SHALL have parameter N_BANK, default 2, meaning point-memory banks (power of two, >=2).
REQ-005 SHALL have parameter ID_WORD_W, default 256, meaning ID-memory word width; K = ID_WORD_W/WIDTH_ID IDs per word; IPP = ceil(P_NUM/K) ID words per pass.
REQ-006 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset; one clock, asynchronous active-low reset.
REQ-008 SHALL have port load_start  in  1  pulse: begin filling the write bank.
REQ-009 SHALL have port load_rdy  out  1  write bank empty and no load active.
REQ-010 SHALL have port w_en / w_addr / w_bank  out  1 / log2(P_NUM) / log2(N_BANK)  point-memory write strobe, address, bank.
REQ-011 SHALL have port load_done  out  1  one-cycle pulse on last write of a bank.
REQ-012 SHALL have port msm_start  in  1  pulse: begin reading the read bank.
REQ-013 SHALL have port cfg_npass  in  8  pass count, sampled at accepted msm_start; 0 treated as 1.
REQ-014 SHALL have port pass_next  in  1  pulse: release the next pass.
REQ-015 SHALL have port r_en / r_addr / r_bank  out  1 / log2(P_NUM) / log2(N_BANK)  point-memory read.
REQ-016 SHALL have port id_r_en / id_r_addr  out  1 / log2(N_BANK*256*IPP)  ID-memory read.
REQ-017 SHALL have port data_i / id_i  in  2*WIDTH_DATA / ID_WORD_W  memory read data, valid 1 cycle after r_en/id_r_en.
REQ-018 SHALL have port out_valid / out_rdy / data_o  out / in / out  1 / 1 / WIDTH_ID+2*WIDTH_DATA  point stream {id, data}.
REQ-019 SHALL have port pass_done / msm_done  out  1 / 1  pulses on last output of a pass / of the final pass.
REQ-020 SHALL have port bank_full  out  N_BANK  per-bank full flag.

Function
REQ-021 SHALL keep wr_ptr and rd_ptr, each advancing by 1 modulo N_BANK.
REQ-022 SHALL accept load_start only when load_rdy=1; otherwise ignore it.
REQ-023 SHALL, on accepted load, assert w_en for exactly P_NUM consecutive cycles starting next cycle, w_addr 0..P_NUM-1, w_bank=wr_ptr.
REQ-024 SHALL, on last write, pulse load_done, set bank_full[wr_ptr], and advance wr_ptr in the same cycle.
REQ-025 SHALL use read FSM states IDLE, STREAM, WAIT_PASS.
REQ-026 SHALL accept msm_start only in IDLE with bank_full[rd_ptr]=1, entering STREAM with pass=0, idx=0; otherwise ignore it.
REQ-027 SHALL in STREAM issue r_en with r_addr=idx and r_bank=rd_ptr only when (output-buffer entries + reads in flight) < 2, and issue id_r_en in the same cycle with id_r_addr = (rd_ptr*cfg_npass_latched + pass)*IPP + idx/K.
REQ-028 SHALL capture {id_i[(idx mod K)*WIDTH_ID +: WIDTH_ID], data_i} into a 2-entry output FIFO on the cycle after the read.
REQ-029 SHALL present out_valid while FIFO is non-empty; an entry pops when out_valid & out_rdy; order is preserved and no data is lost under any out_rdy pattern.
REQ-030 SHALL pulse pass_done when the P_NUM-th point of a pass pops; then enter WAIT_PASS if passes remain, else clear bank_full[rd_ptr], advance rd_ptr, pulse msm_done, and enter IDLE.
REQ-031 SHALL in WAIT_PASS on pass_next increment pass, clear idx, and enter STREAM; pass_next in other states SHALL be ignored.
REQ-032 SHALL permit a load of one bank concurrently with reading another; load_start and msm_start in the same cycle are both honoured.
REQ-033 SHALL never read a bank with bank_full=0 nor write a bank with bank_full=1.

Reset
REQ-034 SHALL, on rst_n low, asynchronously clear all pointers, counters, FSM (to IDLE), FIFO, bank_full, and all outputs to 0 except load_rdy, which becomes 1; an in-progress load or stream is abandoned.

Verification
REQ-035 SHALL cover: load_start after reset -> w_en cycles 1..16, w_addr 0..15, w_bank 0; load_done at cycle 16; bank_full=2'b01.
REQ-036 SHALL cover: bank 0 full, msm_start with cfg_npass=1, out_rdy=1 -> 16 outputs in order, IDs from id word 0 slices 0..15, msm_done, bank_full=0.
REQ-037 SHALL cover: cfg_npass=3 with pass_next 5 cycles after each pass_done -> 48 outputs, id_r_addr 0,1,2, msm_done after third pass only.
REQ-038 SHALL cover: random out_rdy (50%) -> output sequence identical to the out_rdy=1 case, with out_valid never dropping without a pop.
REQ-039 SHALL cover: read bank 0 while loading bank 1, then msm_start immediately after msm_done -> bank 1 streamed with no gap; load_start with both banks full is ignored.
REQ-040 SHALL cover: rst_n low mid-stream at point 7 -> outputs 0 and load_rdy=1 immediately; a subsequent msm_start is ignored because bank_full=0.
